// File: rtl/pd_pkg.sv
// Shared types and widths for the PD axis sequencer and its engine link.
package pd_pkg;

   localparam int ANG_W   = 16;
   localparam int PTERM_W = 10;
   localparam int DTERM_W = 12;

   typedef enum logic [1:0] {
      AX_PTCH = 2'd0,
      AX_ROLL = 2'd1,
      AX_YAW  = 2'd2
   } axis_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } seq_state_t;

   typedef struct packed {
      logic signed [PTERM_W-1:0] pterm;
      logic signed [DTERM_W-1:0] dterm;
   } pd_result_t;

endpackage

// File: rtl/pd_axis_sequencer_if.sv
// Request/response link between the sequencer (master) and the PD math engine (slave).
interface pd_axis_sequencer_if;
   import pd_pkg::*;

   logic                      pd_vld;
   axis_t                     pd_axis;
   logic signed [ANG_W-1:0]   pd_desired;
   logic signed [ANG_W-1:0]   pd_actual;

   // Response tag is raw bits so an illegal tag of 3 can be carried and flagged.
   logic                      pd_rsp_vld;
   logic [1:0]                pd_rsp_axis;
   logic signed [PTERM_W-1:0] pd_rsp_pterm;
   logic signed [DTERM_W-1:0] pd_rsp_dterm;

   modport master (
      output pd_vld, pd_axis, pd_desired, pd_actual,
      input  pd_rsp_vld, pd_rsp_axis, pd_rsp_pterm, pd_rsp_dterm
   );

   modport slave (
      input  pd_vld, pd_axis, pd_desired, pd_actual,
      output pd_rsp_vld, pd_rsp_axis, pd_rsp_pterm, pd_rsp_dterm
   );

endinterface

// File: rtl/pd_axis_sequencer.sv
// Time-multiplexes one pipelined PD engine across pitch/roll/yaw and commits
// the three tagged responses as one atomic result set.
module pd_axis_sequencer
   import pd_pkg::*;
#(
   parameter int LATENCY = 2,
   parameter int TMO     = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      vld,
   input  logic signed [ANG_W-1:0]   d_ptch,
   input  logic signed [ANG_W-1:0]   d_roll,
   input  logic signed [ANG_W-1:0]   d_yaw,
   input  logic signed [ANG_W-1:0]   ptch,
   input  logic signed [ANG_W-1:0]   roll,
   input  logic signed [ANG_W-1:0]   yaw,
   input  logic                      clr_flags,
   pd_axis_sequencer_if.master       pd,
   output logic signed [PTERM_W-1:0] ptch_pterm,
   output logic signed [PTERM_W-1:0] roll_pterm,
   output logic signed [PTERM_W-1:0] yaw_pterm,
   output logic signed [DTERM_W-1:0] ptch_dterm,
   output logic signed [DTERM_W-1:0] roll_dterm,
   output logic signed [DTERM_W-1:0] yaw_dterm,
   output logic                      done,
   output logic                      busy,
   output logic                      ovr,
   output logic                      err
);

   localparam int TMO_LOAD = LATENCY + TMO;
   localparam int CNT_W    = $clog2(TMO_LOAD + 1);

   seq_state_t              state, state_nxt;
   logic [1:0]              idx;
   logic [CNT_W-1:0]        cnt;
   logic [2:0]              mask, mask_nxt;
   logic [3:0]              tag_hot;
   logic                    rsp_ok, rsp_bad, timeout;
   pd_result_t              shadow   [3];
   logic signed [ANG_W-1:0] snap_des [3];
   logic signed [ANG_W-1:0] snap_act [3];

   assign tag_hot = 4'b0001 << pd.pd_rsp_axis;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_nxt = state;
      mask_nxt  = mask;
      rsp_ok    = 1'b0;
      rsp_bad   = 1'b0;
      timeout   = 1'b0;

      // Tag 3 or an already-filled slot is discarded and flagged.
      if (pd.pd_rsp_vld) begin
         if ((state == ISSUE || state == WAIT) && !tag_hot[3] && !(|(tag_hot[2:0] & mask))) begin
            rsp_ok   = 1'b1;
            mask_nxt = mask | tag_hot[2:0];
         end else begin
            rsp_bad  = 1'b1;
         end
      end

      case (state)
         IDLE:    if (vld) state_nxt = ISSUE;
         ISSUE:   if (idx == 2'(AX_YAW)) state_nxt = WAIT;
         WAIT: begin
            if (mask_nxt == 3'b111) begin
               state_nxt = DONE;
            end else if (cnt == CNT_W'(1)) begin
               timeout   = 1'b1;
               state_nxt = IDLE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign pd.pd_vld     = (state == ISSUE);
   assign pd.pd_axis    = (state == ISSUE) ? axis_t'(idx) : AX_PTCH;
   assign pd.pd_desired = (state == ISSUE) ? snap_des[idx] : '0;
   assign pd.pd_actual  = (state == ISSUE) ? snap_act[idx] : '0;
   assign busy          = (state != IDLE);

   // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: the snapshot is pure data qualified by the FSM, so it carries no reset.
   always_ff @(posedge clk) begin
      if (state == IDLE && vld) begin
         snap_des[0] <= d_ptch;
         snap_des[1] <= d_roll;
         snap_des[2] <= d_yaw;
         snap_act[0] <= ptch;
         snap_act[1] <= roll;
         snap_act[2] <= yaw;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx        <= '0;
         cnt        <= '0;
         mask       <= '0;
         done       <= 1'b0;
         ovr        <= 1'b0;
         err        <= 1'b0;
         ptch_pterm <= '0;
         roll_pterm <= '0;
         yaw_pterm  <= '0;
         ptch_dterm <= '0;
         roll_dterm <= '0;
         yaw_dterm  <= '0;
         for (int a = 0; a < 3; a++) shadow[a] <= '0;
      end else begin
         done <= 1'b0;

         if (state == IDLE) begin
            idx  <= '0;
            mask <= '0;
         end else begin
            mask <= mask_nxt;
         end

         if (state == ISSUE) idx <= idx + 2'd1;

         if (state == ISSUE && idx == 2'(AX_YAW)) cnt <= CNT_W'(TMO_LOAD);
         else if (state == WAIT)                  cnt <= cnt - CNT_W'(1);

         if (rsp_ok)
            shadow[pd.pd_rsp_axis] <= '{pterm: pd.pd_rsp_pterm, dterm: pd.pd_rsp_dterm};

         // All six results move in one edge; done marks their first visible cycle.
         if (state == DONE) begin
            ptch_pterm <= shadow[0].pterm;
            roll_pterm <= shadow[1].pterm;
            yaw_pterm  <= shadow[2].pterm;
            ptch_dterm <= shadow[0].dterm;
            roll_dterm <= shadow[1].dterm;
            yaw_dterm  <= shadow[2].dterm;
            done       <= 1'b1;
         end

         if (vld && state != IDLE)  ovr <= 1'b1;
         else if (clr_flags)        ovr <= 1'b0;

         if (rsp_bad || timeout)    err <= 1'b1;
         else if (clr_flags)        err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pd_axis_sequencer.sv
// Directed bench for pd_axis_sequencer with a behavioural tagged PD engine model.
module tb_pd_axis_sequencer;
   import pd_pkg::*;

   localparam int LAT = 2;
   localparam int TMO = 16;

   logic clk, rst, vld, clr_flags;
   logic signed [15:0] d_ptch, d_roll, d_yaw, ptch, roll, yaw;
   logic signed [9:0]  ptch_pterm, roll_pterm, yaw_pterm;
   logic signed [11:0] ptch_dterm, roll_dterm, yaw_dterm;
   logic done, busy, ovr, err;

   pd_axis_sequencer_if pd ();

   pd_axis_sequencer #(.LATENCY(LAT), .TMO(TMO)) dut (
      .clk(clk), .rst(rst), .vld(vld),
      .d_ptch(d_ptch), .d_roll(d_roll), .d_yaw(d_yaw),
      .ptch(ptch), .roll(roll), .yaw(yaw),
      .clr_flags(clr_flags), .pd(pd),
      .ptch_pterm(ptch_pterm), .roll_pterm(roll_pterm), .yaw_pterm(yaw_pterm),
      .ptch_dterm(ptch_dterm), .roll_dterm(roll_dterm), .yaw_dterm(yaw_dterm),
      .done(done), .busy(busy), .ovr(ovr), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int e0, at, d0, r0;
   int req_cnt  = 0;
   int done_cnt = 0;

   // Engine model: per-axis response table, per-axis delay and withhold flags.
   int                 delay_q [3];
   bit                 hold_q  [3];
   logic signed [9:0]  tbl_p   [3];
   logic signed [11:0] tbl_d   [3];
   logic signed [9:0]  exp_p   [3];
   logic signed [11:0] exp_d   [3];
   logic signed [15:0] exp_des [3];
   logic signed [15:0] exp_act [3];

   // Response schedule keyed by the clock edge that samples it.
   bit                 s_v [int];
   logic [1:0]         s_t [int];
   logic signed [9:0]  s_p [int];
   logic signed [11:0] s_d [int];

   task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic void sched(input int e, input logic [1:0] t,
                                 input logic signed [9:0] p, input logic signed [11:0] d);
      s_v[e] = 1'b1;
      s_t[e] = t;
      s_p[e] = p;
      s_d[e] = d;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      int nxt;
      nxt = cyc + 1;
      if (pd.pd_vld === 1'b1) begin
         req_cnt++;
         if (!hold_q[pd.pd_axis])
            sched(nxt + delay_q[pd.pd_axis], pd.pd_axis, tbl_p[pd.pd_axis], tbl_d[pd.pd_axis]);
      end
      if (done === 1'b1) done_cnt++;
      if (s_v.exists(nxt)) begin
         pd.pd_rsp_vld   = 1'b1;
         pd.pd_rsp_axis  = s_t[nxt];
         pd.pd_rsp_pterm = s_p[nxt];
         pd.pd_rsp_dterm = s_d[nxt];
      end else begin
         pd.pd_rsp_vld   = 1'b0;
         pd.pd_rsp_axis  = 2'd0;
         pd.pd_rsp_pterm = '0;
         pd.pd_rsp_dterm = '0;
      end
   end

   task automatic program_engine(input logic signed [9:0] p0, input logic signed [11:0] dd0,
                                 input logic signed [9:0] p1, input logic signed [11:0] dd1,
                                 input logic signed [9:0] p2, input logic signed [11:0] dd2);
      tbl_p[0] = p0; tbl_d[0] = dd0;
      tbl_p[1] = p1; tbl_d[1] = dd1;
      tbl_p[2] = p2; tbl_d[2] = dd2;
   endtask

   task automatic set_delays(input int a, input int b, input int c);
      delay_q[0] = a; delay_q[1] = b; delay_q[2] = c;
   endtask

   task automatic expect_tbl();
      for (int a = 0; a < 3; a++) begin
         exp_p[a] = tbl_p[a];
         exp_d[a] = tbl_d[a];
      end
   endtask

   task automatic pulse(input logic signed [15:0] dp, dr, dy, ap, ar, ay);
      @(negedge clk);
      d_ptch = dp; d_roll = dr; d_yaw = dy;
      ptch   = ap; roll   = ar; yaw   = ay;
      exp_des[0] = dp; exp_des[1] = dr; exp_des[2] = dy;
      exp_act[0] = ap; exp_act[1] = ar; exp_act[2] = ay;
      vld = 1'b1;
      e0  = cyc + 1;
      @(negedge clk);
      vld = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int edge_at);
      edge_at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            edge_at = cyc;
            break;
         end
      end
   endtask

   task automatic clear_flags();
      @(negedge clk);
      clr_flags = 1'b1;
      @(negedge clk);
      clr_flags = 1'b0;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_ptch_p"}, 32'(ptch_pterm), 32'(exp_p[0]));
      chk({tag, "_roll_p"}, 32'(roll_pterm), 32'(exp_p[1]));
      chk({tag, "_yaw_p"},  32'(yaw_pterm),  32'(exp_p[2]));
      chk({tag, "_ptch_d"}, 32'(ptch_dterm), 32'(exp_d[0]));
      chk({tag, "_roll_d"}, 32'(roll_dterm), 32'(exp_d[1]));
      chk({tag, "_yaw_d"},  32'(yaw_dterm),  32'(exp_d[2]));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; vld = 1'b0; clr_flags = 1'b0;
      d_ptch = '0; d_roll = '0; d_yaw = '0; ptch = '0; roll = '0; yaw = '0;
      pd.pd_rsp_vld = 1'b0; pd.pd_rsp_axis = 2'd0; pd.pd_rsp_pterm = '0; pd.pd_rsp_dterm = '0;
      set_delays(LAT, LAT, LAT);
      for (int a = 0; a < 3; a++) begin
         hold_q[a] = 1'b0; exp_p[a] = '0; exp_d[a] = '0;
      end
      program_engine(10'sd318, 12'sd0, 10'sh2C0, 12'sh1C0, 10'sd0, 12'sd170);

      // Reset state
      repeat (2) @(negedge clk);
      check_outputs("rst");
      chk("rst_done", 32'(done), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ovr",  32'(ovr),  0);
      chk("rst_err",  32'(err),  0);
      chk("rst_pd_vld", 32'(pd.pd_vld), 0);
      rst = 1'b0;

      // Basic in-order batch
      d0 = done_cnt; r0 = req_cnt;
      pulse(16'sh0000, 16'sh1234, 16'sh8000, 16'sh7FFF, -16'sd5, 16'sh0001);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("t1_req%0d_vld", k),  32'(pd.pd_vld), 1);
         chk($sformatf("t1_req%0d_axis", k), 32'(pd.pd_axis), k);
         chk($sformatf("t1_req%0d_des", k),  32'(pd.pd_desired), 32'(exp_des[k]));
         chk($sformatf("t1_req%0d_act", k),  32'(pd.pd_actual), 32'(exp_act[k]));
         chk($sformatf("t1_req%0d_busy", k), 32'(busy), 1);
         @(negedge clk);
      end
      chk("t1_req_end", 32'(pd.pd_vld), 0);
      wait_done(20, at);
      chk("t1_done_edge", at - e0, LAT + 4);
      expect_tbl();
      check_outputs("t1");
      chk("t1_err", 32'(err), 0);
      repeat (2) @(negedge clk);
      chk("t1_done_cnt", done_cnt - d0, 1);
      chk("t1_req_cnt", req_cnt - r0, 3);
      chk("t1_busy_after", 32'(busy), 0);

      // Out-of-order responses: YAW, PTCH, ROLL
      set_delays(4, 4, 1);
      d0 = done_cnt;
      pulse(16'sh0000, 16'sh1234, 16'sh8000, 16'sh7FFF, -16'sd5, 16'sh0001);
      wait_done(20, at);
      chk("t2_done_edge", at - e0, 7);
      check_outputs("t2");
      repeat (2) @(negedge clk);
      chk("t2_done_cnt", done_cnt - d0, 1);
      chk("t2_err", 32'(err), 0);

      // Samples dropped mid-batch (including the DONE cycle), extreme result values
      set_delays(LAT, LAT, LAT);
      program_engine(-10'sd1, 12'sh800, 10'sh1FF, 12'sh7FF, 10'sh200, 12'sd1);
      d0 = done_cnt; r0 = req_cnt;
      pulse(16'sh0100, 16'sh0200, 16'sh0300, 16'sh0400, 16'sh0500, 16'sh0600);
      for (int k = 0; k < 10; k++) begin
         vld = (cyc + 1 == e0 + 2) || (cyc + 1 == e0 + 6);
         if (vld) begin
            d_ptch = 16'sh5555; ptch = 16'sh5555;
         end
         @(negedge clk);
      end
      vld = 1'b0;
      expect_tbl();
      check_outputs("t3");
      chk("t3_ovr", 32'(ovr), 1);
      chk("t3_err", 32'(err), 0);
      chk("t3_done_cnt", done_cnt - d0, 1);
      chk("t3_req_cnt", req_cnt - r0, 3);
      clear_flags();
      chk("t3_ovr_clr", 32'(ovr), 0);

      // ROLL response withheld -> timeout, nothing committed
      program_engine(10'sd5, 12'sd6, 10'sd7, 12'sd8, 10'sd9, 12'sd10);
      hold_q[1] = 1'b1;
      d0 = done_cnt;
      pulse(16'sh0011, 16'sh0022, 16'sh0033, 16'sh0044, 16'sh0055, 16'sh0066);
      repeat (3 + LAT + TMO - 1) @(negedge clk);
      chk("t4_err_early", 32'(err), 0);
      chk("t4_busy_wait", 32'(busy), 1);
      @(negedge clk);
      chk("t4_err", 32'(err), 1);
      chk("t4_busy_after", 32'(busy), 0);
      repeat (2) @(negedge clk);
      chk("t4_done_cnt", done_cnt - d0, 0);
      check_outputs("t4_hold");
      hold_q[1] = 1'b0;
      clear_flags();
      chk("t4_err_clr", 32'(err), 0);

      // Duplicate PTCH tag then tag 3; clr_flags collides with the tag-3 error
      program_engine(10'sd100, -12'sd100, -10'sd200, 12'sd2000, 10'sd3, -12'sd3);
      set_delays(LAT, 4, 4);
      d0 = done_cnt;
      pulse(16'sh0001, 16'sh0002, 16'sh0003, 16'sh0004, 16'sh0005, 16'sh0006);
      sched(e0 + 4, 2'd0, 10'sd7, 12'sd7);
      sched(e0 + 5, 2'd3, 10'sd1, 12'sd1);
      repeat (3) @(negedge clk);
      chk("t5_err_pre", 32'(err), 0);
      @(negedge clk);
      chk("t5_err_dup", 32'(err), 1);
      clr_flags = 1'b1;
      @(negedge clk);
      clr_flags = 1'b0;
      chk("t5_err_tag3_wins", 32'(err), 1);
      wait_done(20, at);
      chk("t5_done_edge", at - e0, 8);
      expect_tbl();
      check_outputs("t5");
      repeat (2) @(negedge clk);
      chk("t5_done_cnt", done_cnt - d0, 1);
      clear_flags();

      // Reset between the second and third responses
      program_engine(10'sd11, 12'sd22, 10'sd33, 12'sd44, 10'sd55, 12'sd66);
      set_delays(LAT, LAT, 3);
      d0 = done_cnt;
      pulse(16'sh0101, 16'sh0202, 16'sh0303, 16'sh0404, 16'sh0505, 16'sh0606);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int a = 0; a < 3; a++) begin
         exp_p[a] = '0; exp_d[a] = '0;
      end
      check_outputs("t6_rst");
      chk("t6_busy", 32'(busy), 0);
      chk("t6_done", 32'(done), 0);
      chk("t6_err_rst", 32'(err), 0);
      chk("t6_pd_vld", 32'(pd.pd_vld), 0);
      @(negedge clk);
      chk("t6_err_late", 32'(err), 1);
      chk("t6_done_cnt", done_cnt - d0, 0);
      clear_flags();
      program_engine(10'sd318, 12'sd0, 10'sh2C0, 12'sh1C0, 10'sd0, 12'sd170);
      set_delays(LAT, LAT, LAT);
      pulse(16'sh0000, 16'sh1234, 16'sh8000, 16'sh7FFF, -16'sd5, 16'sh0001);
      wait_done(20, at);
      chk("t6_done_edge", at - e0, LAT + 4);
      expect_tbl();
      check_outputs("t6_fresh");
      chk("t6_err_fresh", 32'(err), 0);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
